// File: rtl/gmii_capture_ctrl.sv
// GMII frame capture sequencer: packs received bytes into BRAM words.
// Optional GMII_CAPTURE_TIMESTAMP_EN writes a cycle-count header per frame.
module gmii_capture_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int MAX_FRAMES_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              gmii_rxd,
  input  logic                    gmii_rx_dv,
  input  logic                    gmii_rx_er,
  input  logic                    arm,
  input  logic                    stop,
  input  logic [MAX_FRAMES_W-1:0] frame_limit,
  output logic                    bram_wr,
  output logic [ADDR_WIDTH-1:0]   bram_waddr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  output logic [ADDR_WIDTH-1:0]   bram_raddr,
  input  logic [DATA_WIDTH-1:0]   bram_rdata,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_ack,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic [MAX_FRAMES_W-1:0] frame_count,
  output logic                    overflow,
  output logic                    err_seen
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state;
  logic [7:0]              rxd_q;
  logic                    dv_q;
  logic                    dv_qq;
  logic                    er_q;
  logic [1:0]              lane;
  logic [DATA_WIDTH-1:0]   pack;
  logic                    stop_seen;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic                    frame_start;
  logic                    is_full;
  logic                    no_room;
  logic                    more;
  logic [MAX_FRAMES_W:0]   fc_next;
  logic [ADDR_WIDTH:0]     wc_next;

`ifdef GMII_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts;
`endif

  assign frame_start = dv_q & ~dv_qq;
  assign is_full     = (word_count == FULL);
  assign wc_next     = word_count + 1'b1;
  assign fc_next     = {1'b0, frame_count} + 1'b1;
  assign more        = (frame_limit == '0) ||
                       (fc_next < {1'b0, frame_limit});

  // With a header, a frame needs at least two free words to start.
`ifdef GMII_CAPTURE_TIMESTAMP_EN
  assign no_room = word_count[ADDR_WIDTH] |
                   (&word_count[ADDR_WIDTH-1:0]);
`else
  assign no_room = is_full;
`endif

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rxd_q       <= '0;
      dv_q        <= 1'b0;
      dv_qq       <= 1'b0;
      er_q        <= 1'b0;
      lane        <= '0;
      pack        <= '0;
      stop_seen   <= 1'b0;
      bram_wr     <= 1'b0;
      bram_waddr  <= '0;
      bram_wdata  <= '0;
      word_count  <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      err_seen    <= 1'b0;
`ifdef GMII_CAPTURE_TIMESTAMP_EN
      ts          <= '0;
`endif
    end else begin
      rxd_q   <= gmii_rxd;
      dv_q    <= gmii_rx_dv;
      er_q    <= gmii_rx_er;
      dv_qq   <= dv_q;
      bram_wr <= 1'b0;
`ifdef GMII_CAPTURE_TIMESTAMP_EN
      ts      <= ts + 1'b1;
`endif
      unique case (state)
        IDLE, DONE: begin
          if (arm) begin
            state       <= ARMED;
            word_count  <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
            err_seen    <= 1'b0;
            stop_seen   <= 1'b0;
            lane        <= '0;
            pack        <= '0;
          end
        end
        ARMED: begin
          if (stop) begin
            state <= DONE;
          end else if (frame_start) begin
            if (no_room) begin
              overflow <= 1'b1;
              state    <= DONE;
            end else begin
`ifdef GMII_CAPTURE_TIMESTAMP_EN
              bram_wr    <= 1'b1;
              bram_waddr <= word_count[ADDR_WIDTH-1:0];
              bram_wdata <= ts;
              word_count <= wc_next;
`endif
              pack  <= {{(DATA_WIDTH-8){1'b0}}, rxd_q};
              lane  <= 2'd1;
              state <= CAPTURE;
              if (er_q) err_seen <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (stop) stop_seen <= 1'b1;
          if (dv_q) begin
            if (er_q) err_seen <= 1'b1;
            if (is_full) begin
              overflow <= 1'b1;
              state    <= DONE;
            end else if (lane == 2'd3) begin
              bram_wr    <= 1'b1;
              bram_waddr <= word_count[ADDR_WIDTH-1:0];
              bram_wdata <= {rxd_q, pack[23:0]};
              word_count <= wc_next;
              lane       <= '0;
              pack       <= '0;
            end else begin
              pack[{lane, 3'b000} +: 8] <= rxd_q;
              lane <= lane + 1'b1;
            end
          end else begin
            // Frame end: flush any partial word, then count the frame.
            if (lane != 2'd0) begin
              bram_wr    <= 1'b1;
              bram_waddr <= word_count[ADDR_WIDTH-1:0];
              bram_wdata <= pack;
              word_count <= wc_next;
            end
            lane        <= '0;
            pack        <= '0;
            frame_count <= fc_next[MAX_FRAMES_W-1:0];
            if (!(stop_seen || stop) && more) state <= ARMED;
            else state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read address goes straight to the BRAM so data returns next cycle.
  assign bram_raddr = rd_req ? rd_addr : raddr_q;
  assign rd_data    = rd_ack ? bram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
      rd_ack  <= 1'b0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) raddr_q <= rd_addr;
    end
  end

endmodule

// File: tb/tb_gmii_capture_ctrl.sv
// Scoreboard bench for gmii_capture_ctrl (default depth and a 4-word
// instance for overflow), with BRAM behavioural models.
module tb_gmii_capture_ctrl;

`ifdef GMII_CAPTURE_TIMESTAMP_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic [7:0]  rxd = 0;
  logic        dv = 0;
  logic        er = 0;
  logic        arm1 = 0;
  logic        arm2 = 0;
  logic        stop = 0;
  logic [15:0] flim = 0;
  logic        rd_req = 0;
  logic [7:0]  rd_addr = 0;

  logic        wr1, ack1, busy1, done1, ovf1, err1;
  logic [7:0]  waddr1, raddr1;
  logic [31:0] wdata1, rdata1, rdout1;
  logic [8:0]  wc1;
  logic [15:0] fc1;

  logic        wr2, ack2, busy2, done2, ovf2, err2;
  logic [1:0]  waddr2, raddr2;
  logic [31:0] wdata2, rdout2;
  logic [2:0]  wc2;
  logic [15:0] fc2;
  logic [31:0] zero32 = 0;
  logic        zero1 = 0;
  logic [1:0]  zero2 = 0;

  logic [31:0] mem1 [0:255];
  logic [31:0] shadow [0:255];
  logic [31:0] tbc;

  logic [39:0] q1 [$];
  logic [39:0] q2 [$];
  logic [31:0] rq [$];
  logic [7:0]  fb [0:31];
  logic [31:0] ew [0:7];
  int          en;
  int          ea1, ea2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  gmii_capture_ctrl dut1 (
    .clk(clk), .rst(rst), .gmii_rxd(rxd), .gmii_rx_dv(dv),
    .gmii_rx_er(er), .arm(arm1), .stop(stop), .frame_limit(flim),
    .bram_wr(wr1), .bram_waddr(waddr1), .bram_wdata(wdata1),
    .bram_raddr(raddr1), .bram_rdata(rdata1), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(ack1), .rd_data(rdout1),
    .busy(busy1), .done(done1), .word_count(wc1),
    .frame_count(fc1), .overflow(ovf1), .err_seen(err1)
  );

  gmii_capture_ctrl #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .gmii_rxd(rxd), .gmii_rx_dv(dv),
    .gmii_rx_er(er), .arm(arm2), .stop(stop), .frame_limit(flim),
    .bram_wr(wr2), .bram_waddr(waddr2), .bram_wdata(wdata2),
    .bram_raddr(raddr2), .bram_rdata(zero32), .rd_req(zero1),
    .rd_addr(zero2), .rd_ack(ack2), .rd_data(rdout2),
    .busy(busy2), .done(done2), .word_count(wc2),
    .frame_count(fc2), .overflow(ovf2), .err_seen(err2)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 0;
      shadow[i] = 0;
    end
  end

  // BRAM model: registered read, read-before-write
  always @(posedge clk) begin
    rdata1 <= mem1[raddr1];
    if (wr1) mem1[waddr1] <= wdata1;
  end

  always @(posedge clk) begin
    if (rst) tbc <= 0;
    else tbc <= tbc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr1) begin
      if (q1.size() == 0) begin
        chk("wr1_unexpected", {24'd0, waddr1}, 32'hffffffff);
      end else begin
        logic [39:0] e;
        e = q1.pop_front();
        chk("wr1_addr", {24'd0, waddr1}, {24'd0, e[39:32]});
        chk("wr1_data", wdata1, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && wr2) begin
      if (q2.size() == 0) begin
        chk("wr2_unexpected", {30'd0, waddr2}, 32'hffffffff);
      end else begin
        logic [39:0] e;
        e = q2.pop_front();
        chk("wr2_addr", {30'd0, waddr2}, {24'd0, e[39:32]});
        chk("wr2_data", wdata2, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ack1) begin
      if (rq.size() == 0) begin
        chk("rd_unexpected", rdout1, 32'hffffffff);
      end else begin
        logic [31:0] e;
        e = rq.pop_front();
        chk("rd_data", rdout1, e);
      end
    end
  end

  task automatic push(input bit tgt2, input logic [31:0] d);
    if (tgt2) begin
      q2.push_back({ea2[7:0], d});
      ea2++;
    end else begin
      q1.push_back({ea1[7:0], d});
      shadow[ea1] = d;
      ea1++;
    end
  endtask

  // Drive fb[0..n-1] as one frame; ew[0..en-1] expected when captured.
  task automatic send(input int n, input int er_at, input int arm_at,
                      input int stop_at, input bit tgt2, input bit cap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = fb[i];
      dv = 1;
      er = (i == er_at);
      stop = (i == stop_at);
      if (tgt2) arm2 = (i == arm_at);
      else arm1 = (i == arm_at);
      if (cap && i == 0) begin
        if (H == 1) push(tgt2, tbc + 1);
        for (int k = 0; k < en; k++) push(tgt2, ew[k]);
      end
    end
    @(negedge clk);
    dv = 0; er = 0; rxd = 0; stop = 0; arm1 = 0; arm2 = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_arm(input bit tgt2);
    @(negedge clk);
    if (tgt2) begin arm2 = 1; ea2 = 0; end
    else begin arm1 = 1; ea1 = 0; end
    @(negedge clk);
    arm1 = 0; arm2 = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drained(input string name);
    chk(name, q1.size() + q2.size() + rq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ea1 = 0; ea2 = 0; en = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_done", {31'd0, done1}, 0);
    chk("rst_wc", {23'd0, wc1}, 0);
    chk("rst_fc", {16'd0, fc1}, 0);
    chk("rst_ovf", {31'd0, ovf1}, 0);
    chk("rst_err", {31'd0, err1}, 0);
    chk("rst_wr", {31'd0, wr1}, 0);
    chk("rst_ack", {31'd0, ack1}, 0);

    // 6-byte frame, limit 1
    flim = 1;
    pulse_arm(0);
    chk("t1_busy", {31'd0, busy1}, 1);
    for (int i = 0; i < 6; i++) fb[i] = 8'h11 + 8'(i);
    ew[0] = 32'h14131211; ew[1] = 32'h00001615; en = 2;
    send(6, -1, -1, -1, 0, 1);
    drained("t1_drain");
    chk("t1_wc", {23'd0, wc1}, 2 + H);
    chk("t1_fc", {16'd0, fc1}, 1);
    chk("t1_done", {31'd0, done1}, 1);
    chk("t1_err", {31'd0, err1}, 0);

    // arm during an in-progress frame: that frame is skipped
    for (int i = 0; i < 8; i++) fb[i] = 8'h01 + 8'(i);
    ea1 = 0; en = 0;
    send(8, -1, 2, -1, 0, 0);
    chk("t2_armed", {31'd0, busy1}, 1);
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD;
    ew[0] = 32'hDDCCBBAA; en = 1;
    send(4, -1, -1, -1, 0, 1);
    drained("t2_drain");
    chk("t2_wc", {23'd0, wc1}, 1 + H);
    chk("t2_fc", {16'd0, fc1}, 1);
    chk("t2_done", {31'd0, done1}, 1);

    // 4-word BRAM, 20-byte frame overflows
    flim = 0;
    pulse_arm(1);
    for (int i = 0; i < 20; i++) fb[i] = 8'h20 + 8'(i);
    ew[0] = 32'h23222120; ew[1] = 32'h27262524;
    ew[2] = 32'h2B2A2928; ew[3] = 32'h2F2E2D2C; en = 4 - H;
    send(20, -1, -1, -1, 1, 1);
    drained("t3_drain");
    chk("t3_ovf", {31'd0, ovf2}, 1);
    chk("t3_fc", {16'd0, fc2}, 0);
    chk("t3_done", {31'd0, done2}, 1);
    chk("t3_wc", {29'd0, wc2}, 4);
    chk("t3_dut1_idle", {31'd0, done1}, 1);

    // unlimited, stop mid-frame
    pulse_arm(0);
    for (int i = 0; i < 8; i++) fb[i] = 8'h40 + 8'(i);
    ew[0] = 32'h43424140; ew[1] = 32'h47464544; en = 2;
    send(8, -1, -1, 3, 0, 1);
    drained("t4_drain");
    chk("t4_fc", {16'd0, fc1}, 1);
    chk("t4_wc", {23'd0, wc1}, 2 + H);
    chk("t4_done", {31'd0, done1}, 1);

    // rx_er on byte 3, then back-to-back reads
    flim = 1;
    pulse_arm(0);
    chk("t5_err_clr", {31'd0, err1}, 0);
    for (int i = 0; i < 9; i++) fb[i] = 8'h50 + 8'(i);
    ew[0] = 32'h53525150; ew[1] = 32'h57565554;
    ew[2] = 32'h00000058; en = 3;
    send(9, 3, -1, -1, 0, 1);
    drained("t5_drain");
    chk("t5_err", {31'd0, err1}, 1);
    chk("t5_fc", {16'd0, fc1}, 1);
    chk("t5_ovf", {31'd0, ovf1}, 0);
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      rd_req = 1;
      rd_addr = 8'(a);
      rq.push_back(shadow[a]);
    end
    @(negedge clk);
    rd_req = 0;
    repeat (3) @(negedge clk);
    drained("t5_rd_drain");
    chk("t5_ack_low", {31'd0, ack1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmii_capture_ctrl.md
Name: gmii_capture_ctrl

Overview:
- Sequences capture of received GMII frames into a dual-port capture BRAM (write port, plus read port with 1-cycle registered read) inside the traffic analyzer.
- Arm/stop control, byte-to-word packing, fill/overflow tracking and frame counting.
- Forwards host read requests onto the BRAM read port and returns data with an acknowledge.

Parameters:
- DATA_WIDTH, 32, BRAM word width; fixed at 32 (4 bytes per word, byte 0 in bits [7:0]).
- ADDR_WIDTH, 8, BRAM address width; depth DEPTH = 2**ADDR_WIDTH words.
- MAX_FRAMES_W, 16, width of frame counter and frame limit.

Ports:
- clk  in  1  single clock for all logic and both BRAM ports
- rst  in  1  synchronous, active-high reset
- gmii_rxd  in  8  receive data
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- arm  in  1  pulse: start a capture session
- stop  in  1  pulse: end session after current frame
- frame_limit  in  MAX_FRAMES_W  frames to capture; 0 = unlimited
- bram_wr  out  1  BRAM write enable
- bram_waddr  out  ADDR_WIDTH  BRAM write address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- bram_raddr  out  ADDR_WIDTH  BRAM read address
- bram_rdata  in  DATA_WIDTH  BRAM read data, valid 1 cycle after bram_raddr
- rd_req  in  1  host read request, 1 cycle
- rd_addr  in  ADDR_WIDTH  host read word address
- rd_ack  out  1  read data valid
- rd_data  out  DATA_WIDTH  read data
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  state is DONE
- word_count  out  ADDR_WIDTH+1  words written this session
- frame_count  out  MAX_FRAMES_W  frames completed this session
- overflow  out  1  sticky: BRAM filled mid-session
- err_seen  out  1  sticky: rx_er seen during a captured frame

Behaviour:
- Reset: state IDLE; all outputs 0; bram_raddr 0; byte lane 0; counters 0.
- Inputs are registered 1 stage; frame start = dv 0->1 on the registered input, frame end = dv 1->0.
- States:
  - IDLE: arm -> ARMED; clears word_count, frame_count, overflow, err_seen.
  - ARMED: waits for a frame start; a frame already in progress at arm is skipped. stop -> DONE.
  - CAPTURE: packs bytes lane 0..3. When lane 3 fills, or at frame end with a partial word (unused upper bytes = 0), the word is written; bram_wr pulses 1 cycle; bram_waddr = word_count; word_count increments.
    - Every frame starts on a new word.
    - At frame end, frame_count increments. Return to ARMED if (stop not seen and (frame_limit==0 or frame_count+1 < frame_limit)), else DONE.
  - DONE: arm -> ARMED with counters cleared; otherwise hold.
- stop during CAPTURE is latched; the current frame completes and flushes first.
- Full: word_count == DEPTH blocks further writes. If bytes remain in the frame, or a new frame starts, set overflow and go to DONE. The truncated frame is not counted.
- rx_er with dv in CAPTURE sets err_seen; bytes are still stored.
- arm in CAPTURE is ignored. rst mid-frame returns to IDLE immediately; no flush.
- Write latency: last byte of a word on gmii_rxd -> bram_wr 2 cycles later.
- Read path (any state, independent of capture):
  - bram_raddr = rd_addr on rd_req, else holds.
  - rd_ack 1 cycle after rd_req, with rd_data = bram_rdata.
  - Back-to-back requests every cycle are allowed.
- Simultaneous write and read to the same address: read returns old data.

Optional Feature:
- GMII_CAPTURE_TIMESTAMP_EN
- Defined:
  - 32-bit free-running cycle counter, reset to 0.
  - On each captured frame start, a header word = counter value at the frame start is written before the frame data.
  - If only one word is left, the header is not written: overflow and DONE.
- Undefined: no counter, no header; data only.

Test Plan:
- Arm, one 6-byte frame 11..16, frame_limit=1 -> writes addr0=0x14131211 and addr1=0x00001615; word_count=2, frame_count=1, done=1.
- Arm during an in-progress frame, then a 4-byte frame AA BB CC DD -> first frame skipped; single write 0xDDCCBBAA at addr0.
- ADDR_WIDTH=2, frame of 20 bytes -> 4 writes, overflow=1, frame_count=0, done=1, no write beyond addr3.
- frame_limit=0, stop pulsed mid-frame of 8 bytes -> both words written, frame_count=1, then DONE.
- Frame with rx_er on byte 3 -> err_seen=1, data stored unchanged. Then rd_req addr0,1,2 on consecutive cycles -> three rd_ack pulses with matching data one cycle later.
- Timestamp build: frame start at counter 0x64 -> addr0=0x00000064, data from addr1.
